// File: rtl/alu_sequencer_if.sv
// Command channel into the ALU sequencer: valid/ready handshake plus a
// register-to-register command (opcode, destination, two sources, count).
interface alu_sequencer_if #(
  parameter int unsigned AW = 3,
  parameter int unsigned CW = 4
) ();

  logic          cmd_valid;
  logic          cmd_ready;
  logic [4:0]    cmd_op;
  logic [AW-1:0] cmd_dst;
  logic [AW-1:0] cmd_srca;
  logic [AW-1:0] cmd_srcb;
  logic [CW-1:0] cmd_count;

  // Command issuer
  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_dst,
    output cmd_srca,
    output cmd_srcb,
    output cmd_count,
    input  cmd_ready
  );

  // Sequencer side
  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_dst,
    input  cmd_srca,
    input  cmd_srcb,
    input  cmd_count,
    output cmd_ready
  );

endinterface

// File: rtl/alu_sequencer.sv
// Command sequencer around a 16-bit combinational ALU. Holds the register
// file and the architectural flags, issues one command at a time, iterates
// shift/rotate ops with carry chaining, then writes the result back.
module alu_sequencer #(
  parameter int unsigned W    = 16,
  parameter int unsigned NREG = 8,
  parameter int unsigned AW   = 3,
  parameter int unsigned CW   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_sequencer_if.slave cmd,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [4:0]    alu_f,
  output logic          alu_cin,
  input  logic [W-1:0]  alu_result,
  input  logic [5:0]    alu_status,
  output logic [5:0]    flags,
  output logic          done,
  output logic          done_err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StWb   = 2'd2;

  // Flag bit positions
  localparam int unsigned FlC = 5;
  localparam int unsigned FlZ = 4;
  localparam int unsigned FlN = 3;
  localparam int unsigned FlV = 2;
  localparam int unsigned FlP = 1;
  localparam int unsigned FlA = 0;

  logic [1:0]    state_q, state_d;
  logic [4:0]    op_q, op_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [W-1:0]  work_q, work_d;
  logic [W-1:0]  opb_q, opb_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [5:0]    flags_q, flags_d;
  logic          err_q, err_d;
  logic [W-1:0]  regs_q [NREG];

  logic accept;

  function automatic logic is_arith(input logic [4:0] f);
    return (f == 5'b00001) || (f == 5'b00011) || (f[4:2] == 3'b001);
  endfunction

  function automatic logic is_logic(input logic [4:0] f);
    return f[4:2] == 3'b010;
  endfunction

  function automatic logic is_shift(input logic [4:0] f);
    return f[4:3] == 2'b10;
  endfunction

  assign accept = cmd.cmd_valid && (state_q == StIdle);

  // Next-state: command latch in IDLE, per-iteration ALU capture in EXEC
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dst_d   = dst_q;
    work_d  = work_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    flags_d = flags_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          op_d   = cmd.cmd_op;
          dst_d  = cmd.cmd_dst;
          // Regfile q values: a same-edge external write is not seen here
          work_d = regs_q[cmd.cmd_srca];
          opb_d  = regs_q[cmd.cmd_srcb];
          if (is_arith(cmd.cmd_op) || is_logic(cmd.cmd_op)) begin
            err_d   = 1'b0;
            rem_d   = CW'(1);
            state_d = StExec;
          end else if (is_shift(cmd.cmd_op)) begin
            err_d   = 1'b0;
            rem_d   = (cmd.cmd_count == '0) ? CW'(1) : cmd.cmd_count;
            state_d = StExec;
          end else begin
            // Illegal opcode: skip EXEC, flag the completion as an error
            err_d   = 1'b1;
            rem_d   = '0;
            state_d = StWb;
          end
        end
      end
      StExec: begin
        work_d = alu_result;
        rem_d  = rem_q - CW'(1);
        if (is_arith(op_q)) begin
          flags_d = alu_status;
        end else if (is_logic(op_q)) begin
          flags_d[FlC] = 1'b0;
          flags_d[FlZ] = alu_status[FlZ];
          flags_d[FlN] = alu_status[FlN];
          flags_d[FlV] = 1'b0;
          flags_d[FlP] = alu_status[FlP];
        end else if (is_shift(op_q)) begin
          // CF updates every step so multi-step RCL/RCR chain through carry
          flags_d[FlC] = alu_status[FlC];
          flags_d[FlZ] = alu_status[FlZ];
          flags_d[FlN] = alu_status[FlN];
          flags_d[FlP] = alu_status[FlP];
        end
        if (rem_q == CW'(1)) begin
          state_d = StWb;
        end
      end
      StWb: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      dst_q   <= '0;
      work_q  <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      work_q  <= work_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  // Register file: external load, then writeback so WB wins on a collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        regs_q[wr_addr] <= wr_data;
      end
      if ((state_q == StWb) && !err_q) begin
        regs_q[dst_q] <= work_q;
      end
    end
  end

  // Outputs come straight from registers so ALU inputs are stable all cycle
  always_comb begin
    cmd.cmd_ready = (state_q == StIdle);
    rd_data       = regs_q[rd_addr];
    alu_a         = work_q;
    alu_b         = opb_q;
    alu_f         = op_q;
    alu_cin       = flags_q[FlC];
    flags         = flags_q;
    done          = (state_q == StWb);
    done_err      = (state_q == StWb) && err_q;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed commands push expected
// completions; a monitor pops and checks them on each done pulse.
module tb_alu_sequencer;

  localparam logic [4:0] OpAdd = 5'b00100;
  localparam logic [4:0] OpAnd = 5'b01000;
  localparam logic [4:0] OpShr = 5'b10001;
  localparam logic [4:0] OpRcl = 5'b10110;
  localparam logic [4:0] OpIll = 5'b11000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rd_addr;
  logic [2:0]  tb_rd_addr;
  logic [2:0]  mon_addr;
  logic        mon_active;
  logic [15:0] rd_data;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_f;
  logic        alu_cin;
  logic [5:0]  alu_status, flags;
  logic        done, done_err;

  alu_sequencer_if #(.AW(3), .CW(4)) cmd_if ();

  alu_sequencer #(.W(16), .NREG(8), .AW(3), .CW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cmd_if),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_f      (alu_f),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_status (alu_status),
    .flags      (flags),
    .done       (done),
    .done_err   (done_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign rd_addr = mon_active ? mon_addr : tb_rd_addr;

  // Minimal ALU model for the ops the directed vectors use
  logic [16:0] alu_sum;
  logic        a_c, a_v, a_af;
  always_comb begin
    alu_sum    = '0;
    alu_result = '0;
    a_c        = 1'b0;
    a_v        = 1'b0;
    a_af       = 1'b0;
    case (alu_f)
      OpAdd: begin
        alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = alu_sum[15:0];
        a_c        = alu_sum[16];
        a_v        = (alu_a[15] == alu_b[15]) && (alu_sum[15] != alu_a[15]);
        a_af       = ({1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]}) > 5'h0F;
      end
      OpAnd: alu_result = alu_a & alu_b;
      OpShr: begin
        alu_result = {1'b0, alu_a[15:1]};
        a_c        = alu_a[0];
      end
      OpRcl: begin
        alu_result = {alu_a[14:0], alu_cin};
        a_c        = alu_a[15];
      end
      default: ;
    endcase
    alu_status = {a_c, alu_result == 16'h0, alu_result[15], a_v, ~^alu_result[7:0], a_af};
  end

  typedef struct {
    logic        err;
    logic [5:0]  fl;
    logic [2:0]  dst;
    logic [15:0] val;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [15:0] exp);
    tb_rd_addr = a;
    #1;
    chk(name, rd_data, exp);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic issue(input string name, input logic [4:0] op, input logic [2:0] dst,
                       input logic [2:0] a, input logic [2:0] b, input logic [3:0] cnt,
                       input logic push, input logic err, input logic [5:0] fl,
                       input logic [15:0] val, input int lat, output int acc);
    int   n;
    exp_t e;
    n = 0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_dst   = dst;
    cmd_if.cmd_srca  = a;
    cmd_if.cmd_srcb  = b;
    cmd_if.cmd_count = cnt;
    while (!cmd_if.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_accept"}, {31'b0, cmd_if.cmd_ready}, 32'd1);
    acc = -1;
    if (cmd_if.cmd_ready) begin
      @(posedge clk);
      #1;
      acc = cyc;
      if (push) begin
        e.err = err; e.fl = fl; e.dst = dst; e.val = val; e.lat = lat; e.acc = acc;
        sb.push_back(e);
      end
      @(negedge clk);
    end
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Monitor: every done pulse must match the oldest expected completion
  initial begin
    exp_t e;
    mon_active = 1'b0;
    mon_addr   = '0;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_done: got done=1, expected no completion");
        end else begin
          e = sb.pop_front();
          chk("done_err", {31'b0, done_err}, {31'b0, e.err});
          chk("flags",    {26'b0, flags},    {26'b0, e.fl});
          chk("latency",  cyc - e.acc,       e.lat);
          mon_addr   = e.dst;
          mon_active = 1'b1;
          @(posedge clk);
          #1;
          chk("writeback", {16'b0, rd_data}, {16'b0, e.val});
          mon_active = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  logic [15:0] shr_seq [5];
  int acc1, acc2, dummy;

  initial begin
    shr_seq[0] = 16'hFFFF; shr_seq[1] = 16'h7FFF; shr_seq[2] = 16'h3FFF;
    shr_seq[3] = 16'h1FFF; shr_seq[4] = 16'h0FFF;
    rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; tb_rd_addr = '0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = '0; cmd_if.cmd_dst = '0;
    cmd_if.cmd_srca = '0; cmd_if.cmd_srcb = '0; cmd_if.cmd_count = '0;
    repeat (3) @(negedge clk);
    chk("rst_done",  {31'b0, done}, 32'd0);
    chk("rst_flags", {26'b0, flags}, 32'd0);
    chk("rst_alu_a", {16'b0, alu_a}, 32'd0);
    chk("rst_alu_f", {27'b0, alu_f}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'b0, cmd_if.cmd_ready}, 32'd1);
    rd_chk("rst_r5", 3'd5, 16'h0000);

    // ADD r3 = r1 + r2 -> 0, flags CF ZF PF AF
    wr(3'd1, 16'hFFFF);
    wr(3'd2, 16'h0001);
    issue("add", OpAdd, 3'd3, 3'd1, 3'd2, 4'd0, 1'b1, 1'b0, 6'h33, 16'h0000, 1, dummy);

    // AND r5 = r3 & r1 -> 0, CF/VF cleared, AF kept
    issue("and", OpAnd, 3'd5, 3'd3, 3'd1, 4'd0, 1'b1, 1'b0, 6'h13, 16'h0000, 1, dummy);

    // RCL x3 on r4 with CF=0; an external write mid-EXEC must not disturb work
    wr(3'd4, 16'h8001);
    issue("rcl", OpRcl, 3'd4, 3'd4, 3'd0, 4'd3, 1'b1, 1'b0, 6'h03, 16'h000A, 3, dummy);
    chk("rcl_a0", {16'b0, alu_a}, 32'h8001);
    chk("rcl_f",  {27'b0, alu_f}, {27'b0, OpRcl});
    chk("rcl_busy", {31'b0, cmd_if.cmd_ready}, 32'd0);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h5555;
    @(negedge clk);
    wr_en = 1'b0;
    chk("rcl_a1", {16'b0, alu_a}, 32'h0002);
    @(negedge clk);
    chk("rcl_a2", {16'b0, alu_a}, 32'h0005);

    // Illegal opcode: error completion, nothing written, flags kept
    issue("ill", OpIll, 3'd4, 3'd0, 3'd0, 4'd0, 1'b1, 1'b1, 6'h03, 16'h000A, 0, dummy);
    @(negedge clk);
    chk("ill_ready", {31'b0, cmd_if.cmd_ready}, 32'd1);

    // SHR with count 0 runs exactly once
    issue("shr0", OpShr, 3'd1, 3'd1, 3'd0, 4'd0, 1'b1, 1'b0, 6'h23, 16'h7FFF, 1, dummy);

    // SHR x15 on r6 aborted by reset on the 5th EXEC cycle
    wr(3'd6, 16'hFFFF);
    issue("shr15", OpShr, 3'd6, 3'd6, 3'd0, 4'd15, 1'b0, 1'b0, 6'h00, 16'h0000, 0, dummy);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("shr_a%0d", k), {16'b0, alu_a}, {16'b0, shr_seq[k]});
      if (k < 4) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("abort_flags", {26'b0, flags}, 32'd0);
    chk("abort_alu_a", {16'b0, alu_a}, 32'd0);
    chk("abort_done",  {31'b0, done},  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk("abort_r6", 3'd6, 16'h0000);
    rd_chk("abort_r4", 3'd4, 16'h0000);
    chk("abort_ready", {31'b0, cmd_if.cmd_ready}, 32'd1);
    repeat (3) @(negedge clk);

    // WB beats a same-edge external write; held valid accepted as ready rises
    wr(3'd1, 16'h7FF8);
    issue("add_wb", OpAdd, 3'd2, 3'd1, 3'd1, 4'd0, 1'b1, 1'b0, 6'h0F, 16'hFFF0, 1, acc1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op = OpAdd; cmd_if.cmd_dst = 3'd7; cmd_if.cmd_srca = 3'd2; cmd_if.cmd_srcb = 3'd2;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hDEAD;
    @(negedge clk);
    wr_en = 1'b0;
    issue("add_b2b", OpAdd, 3'd7, 3'd2, 3'd2, 4'd0, 1'b1, 1'b0, 6'h28, 16'hFFE0, 1, acc2);
    chk("b2b_gap", acc2 - acc1, 32'd3);

    repeat (6) @(negedge clk);
    rd_chk("final_r2", 3'd2, 16'hFFF0);
    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
